std_div_pipe: RTL
=================

# std_div_pipe

Iterative multi-cycle divider for the standard primitive library: a parametrised-width successor to the single-cycle combinational divide. It computes quotient and remainder with one restoring-division step per cycle under a go/done handshake, and holds results in registers. Calyx-generated control drives it like any other go/done component. It replaces the wide combinational divide path on timing-critical designs.

## Interface
- width, 32, operand and result width in bits (≥ 2)
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- go  input  1  start request; sampled only in IDLE
- left  input  width  dividend; captured on the edge that accepts go
- right  input  width  divisor; captured on the edge that accepts go
- out_quotient  output  width  registered quotient of last completed operation
- out_remainder  output  width  registered remainder of last completed operation
- done  output  1  registered one-cycle completion pulse

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE, go=1: latch left/right into internal dividend/divisor registers, clear the partial remainder and the iteration counter (width $clog2(width)+1), then go to RUN. IDLE, go=0: stay.
- RUN, each edge: one restoring step:
  - shift the {partial remainder, dividend} pair left by 1;
  - if the shifted partial remainder (width+1 bits) ≥ divisor, subtract the divisor and shift in quotient bit 1, else shift in 0;
  - increment the counter.
- The step that brings the counter to width writes out_quotient/out_remainder and moves to DONE.
- DONE: done=1 for this cycle only, then unconditionally go to IDLE; go ignored.
- go in RUN/DONE ignored; operand changes after capture have no effect.
- Divide by zero requires no special case: quotient = all ones, remainder = left.
- out_quotient/out_remainder change only on the completing edge or on reset; they are held indefinitely otherwise.
- Reset at any state: state→IDLE, done=0, out_quotient=0, out_remainder=0, internal registers cleared; an in-flight operation is aborted with no done.

## Timing
- Reset values: done=0, out_quotient=0, out_remainder=0, state IDLE.
- Edge E samples go=1 in IDLE → steps on edges E+1..E+width → done high in cycle following edge E+width (latency width cycles from accepting edge), exactly one cycle wide.
- Results are valid in the done cycle and stay valid after it.
- Earliest next acceptance: edge E+width+2 (first IDLE edge); back-to-back throughput width+2 cycles per operation.
- go held high continuously → one operation every width+2 cycles, each using the operands present at its accepting edge.
- reset and go both high on the same edge: reset wins, no operation started.

## Configuration
- STD_DIV_PIPE_SIGNED_EN defined: operands are two's complement. The captured operands are converted to magnitudes. On the completing edge (no extra cycle):
  - the quotient is negated if the operand signs differ;
  - the remainder takes the sign of the dividend (truncating division).
- Signed special cases:
  - most-negative / −1 → quotient = most-negative (wraps), remainder 0;
  - x / 0 → quotient all ones, remainder = left.
- Not defined: purely unsigned division as above; no sign logic synthesised.

## Test plan
- width=8, reset, left=100, right=7, go pulse → done exactly 8 cycles after accepting edge, one cycle wide, out_quotient=14, out_remainder=2; outputs still 14/2 ten cycles later.
- width=8, 37/0 → out_quotient=0xFF, out_remainder=37; 255/1 → 255/0; 3/200 → 0/3.
- go held high, operands 50/5 then switched to 9/4 two cycles after acceptance → first done gives 10/0. Next acceptance occurs at edge E+10 and uses 9/4 → 2/1.
- Reset asserted on the 3rd RUN cycle of 100/7 → done never pulses, outputs 0, state IDLE; a following 200/9 → 22/2 with normal latency.
- Reset and go high on the same edge → no operation, done stays 0 for 20 cycles.
- STD_DIV_PIPE_SIGNED_EN, width=8: −7/2 → 0xFD/0xFF; 7/−2 → 0xFD/0x01; −128/−1 → 0x80/0x00; latency still 8 cycles.

Source files
------------

// File: rtl/std_div_pipe.sv
// Iterative restoring divider: one quotient bit per cycle under a go/done handshake.
// Optional two's-complement mode is enabled with the macro STD_DIV_PIPE_SIGNED_EN.
module std_div_pipe #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [width-1:0] left,
    input  logic [width-1:0] right,
    output logic [width-1:0] out_quotient,
    output logic [width-1:0] out_remainder,
    output logic             done
);

    localparam int CW = $clog2(width) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CW-1:0] LAST_STEP = CW'(width - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic [1:0]       state_q, state_d;
    logic [width-1:0] dvd_q, dvd_d;
    logic [width-1:0] dvs_q, dvs_d;
    logic [width-1:0] rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [width-1:0] quo_out_q, quo_out_d;
    logic [width-1:0] rem_out_q, rem_out_d;
    logic             done_q, done_d;

    logic [width:0]   shifted_s;
    logic [width:0]   diff_s;
    logic             fits_s;
    logic [width-1:0] rem_step_s;
    logic [width-1:0] quo_step_s;
    logic [width-1:0] fin_quo_s;
    logic [width-1:0] fin_rem_s;
    logic [width-1:0] cap_dvd_s;
    logic [width-1:0] cap_dvs_s;

`ifdef STD_DIV_PIPE_SIGNED_EN
    logic neg_quo_q, neg_quo_d;
    logic neg_rem_q, neg_rem_d;

    function automatic logic [width-1:0] cond_neg(input logic [width-1:0] v, input logic n);
        logic [width-1:0] r;
        if (n) begin
            r = width'(0) - v;
        end else begin
            r = v;
        end
        return r;
    endfunction
`endif

    // One restoring step: the dividend register doubles as the quotient shift register.
    always_comb begin
        shifted_s  = {rem_q, dvd_q[width-1]};
        diff_s     = shifted_s - {1'b0, dvs_q};
        fits_s     = (shifted_s >= {1'b0, dvs_q});
        rem_step_s = fits_s ? diff_s[width-1:0] : shifted_s[width-1:0];
        quo_step_s = {dvd_q[width-2:0], fits_s};
    end

`ifdef STD_DIV_PIPE_SIGNED_EN
    // Magnitude capture and final sign fix-up; a zero divisor keeps the all-ones quotient.
    always_comb begin
        cap_dvd_s = cond_neg(left, left[width-1]);
        cap_dvs_s = cond_neg(right, right[width-1]);
        fin_quo_s = cond_neg(quo_step_s, neg_quo_q && (dvs_q != width'(0)));
        fin_rem_s = cond_neg(rem_step_s, neg_rem_q);
    end
`else
    // Unsigned mode passes operands and step results straight through.
    always_comb begin
        cap_dvd_s = left;
        cap_dvs_s = right;
        fin_quo_s = quo_step_s;
        fin_rem_s = rem_step_s;
    end
`endif

    // Control FSM and datapath next-state.
    always_comb begin
        state_d   = state_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        quo_out_d = quo_out_q;
        rem_out_d = rem_out_q;
        done_d    = 1'b0;
`ifdef STD_DIV_PIPE_SIGNED_EN
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
`endif
        case (state_q)
            IDLE: begin
                if (go) begin
                    dvd_d   = cap_dvd_s;
                    dvs_d   = cap_dvs_s;
                    rem_d   = width'(0);
                    cnt_d   = CW'(0);
`ifdef STD_DIV_PIPE_SIGNED_EN
                    neg_quo_d = left[width-1] ^ right[width-1];
                    neg_rem_d = left[width-1];
`endif
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                dvd_d = quo_step_s;
                rem_d = rem_step_s;
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == LAST_STEP) begin
                    quo_out_d = fin_quo_s;
                    rem_out_d = fin_rem_s;
                    done_d    = 1'b1;
                    state_d   = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            dvd_q     <= width'(0);
            dvs_q     <= width'(0);
            rem_q     <= width'(0);
            cnt_q     <= CW'(0);
            quo_out_q <= width'(0);
            rem_out_q <= width'(0);
            done_q    <= 1'b0;
`ifdef STD_DIV_PIPE_SIGNED_EN
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            quo_out_q <= quo_out_d;
            rem_out_q <= rem_out_d;
            done_q    <= done_d;
`ifdef STD_DIV_PIPE_SIGNED_EN
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
`endif
        end
    end

    assign out_quotient  = quo_out_q;
    assign out_remainder = rem_out_q;
    assign done          = done_q;

endmodule
